// File: rtl/decoder_pkg.sv
// Shared state encoding and mode constants for the scanning one-hot decoder.
package decoder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/decoder_scan_dwell_counter.sv
// Loadable down-counter that times how long a scanned line is held.
module dwell_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT and auto-walking SCAN modes.
// Define DECODER_ACTIVE_LOW_EN to drive y active-low (idle value all ones).
module decoder_scan
    import decoder_pkg::*;
#(
    parameter  int SEL_W   = 4,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic               start,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   y,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               busy,
    output logic               wrap
);
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1);

    state_t             state, state_n;
    logic [OUT_W-1:0]   y_q, y_n;
    logic [SEL_W-1:0]   sel_n, nxt_idx;
    logic               busy_n, wrap_n;
    logic               cnt_clr, cnt_load, cnt_dec, cnt_zero;

    dwell_counter #(.W(DWELL_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (dwell),
        .zero     (cnt_zero)
    );

    assign nxt_idx = cur_sel + 1'b1;

    always_comb begin
        state_n  = state;
        y_n      = y_q;
        sel_n    = cur_sel;
        wrap_n   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            y_n     = '0;
            sel_n   = '0;
            cnt_clr = 1'b1;
        end else if (mode == MODE_DIRECT) begin
            state_n = ST_DIRECT;
            y_n     = ONE << sel;
            sel_n   = sel;
            cnt_clr = 1'b1;
        end else if (start) begin
            state_n  = ST_SCAN;
            y_n      = ONE;
            sel_n    = '0;
            cnt_load = 1'b1;
        end else if (state == ST_SCAN) begin
            if (cnt_zero) begin
                // Leaving the last line back to line 0 is the wrap event.
                sel_n    = nxt_idx;
                y_n      = ONE << nxt_idx;
                wrap_n   = (cur_sel == '1);
                cnt_load = 1'b1;
            end else begin
                cnt_dec = 1'b1;
            end
        end
        busy_n = (state_n == ST_SCAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            y_q     <= '0;
            cur_sel <= '0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            y_q     <= y_n;
            cur_sel <= sel_n;
            busy    <= busy_n;
            wrap    <= wrap_n;
        end
    end

`ifdef DECODER_ACTIVE_LOW_EN
    assign y = ~y_q;
`else
    assign y = y_q;
`endif
endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: vector table, corner sequences, random vs model.
module tb_decoder_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  sel = '0;
    logic [7:0]  dwell = '0;
    logic [15:0] y;
    logic [3:0]  cur_sel;
    logic        busy;
    logic        wrap;

    int vectors = 0;
    int errs = 0;

    // reference model: scan timing kept as line length and age in cycles
    int m_st;
    int m_cur;
    int m_len;
    int m_age;
    bit m_wrap;

    always #5 clk = ~clk;

    decoder_scan dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .mode    (mode),
        .start   (start),
        .sel     (sel),
        .dwell   (dwell),
        .y       (y),
        .cur_sel (cur_sel),
        .busy    (busy),
        .wrap    (wrap)
    );

    function automatic logic [15:0] pol(input logic [15:0] hi);
`ifdef DECODER_ACTIVE_LOW_EN
        return ~hi;
`else
        return hi;
`endif
    endfunction

    function automatic logic [15:0] model_y();
        if (m_st == 0) return 16'h0;
        return 16'h1 << m_cur;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cur = 0; m_len = 1; m_age = 1; m_wrap = 0;
    endtask

    task automatic model_step();
        m_wrap = 0;
        if (!enable) begin
            m_st = 0; m_cur = 0;
        end else if (!mode) begin
            m_st = 1; m_cur = int'(sel);
        end else if (start) begin
            m_st = 2; m_cur = 0; m_len = int'(dwell) + 1; m_age = 1;
        end else if (m_st == 2) begin
            if (m_age < m_len) begin
                m_age++;
            end else begin
                m_wrap = (m_cur == 15);
                m_cur  = (m_cur + 1) % 16;
                m_len  = int'(dwell) + 1;
                m_age  = 1;
            end
        end
    endtask

    task automatic compare_all();
        logic [15:0] yh;
        yh = pol(y);
        chk("y", 32'(y), 32'(pol(model_y())));
        chk("cur_sel", 32'(cur_sel), 32'(m_cur));
        chk("busy", 32'(busy), 32'(m_st == 2));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("onehot0", 32'($onehot0(yh)), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit          en;
        bit          md;
        bit          st;
        logic [3:0]  sl;
        logic [15:0] ey;
        logic [3:0]  ecur;
        bit          eb;
    } vec_t;

    vec_t tbl[20];

    initial begin
        model_reset();
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 4'(i), 16'h1 << i, 4'(i), 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 4'd7, 16'h0, 4'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 4'd7, 16'h0, 4'd0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 4'd3, 16'h0008, 4'd3, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 4'd9, 16'h0008, 4'd3, 1'b0};

        #2;
        chk("reset_y", 32'(y), 32'(pol(16'h0)));
        chk("reset_busy", 32'(busy), 32'd0);
        run(2);
        rst = 1'b0;

        // DIRECT sweep and idle/hold cases
        for (int i = 0; i < 20; i++) begin
            enable = tbl[i].en; mode = tbl[i].md;
            start = tbl[i].st; sel = tbl[i].sl;
            tick();
            chk("tbl_y", 32'(y), 32'(pol(tbl[i].ey)));
            chk("tbl_cur", 32'(cur_sel), 32'(tbl[i].ecur));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].eb));
        end

        // full walk with dwell 0 and wrap at cycle 16
        enable = 1; mode = 1; start = 1; dwell = 0;
        tick();
        chk("walk_start", 32'(y), 32'(pol(16'h0001)));
        start = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) chk("walk_last", 32'(y), 32'(pol(16'h8000)));
            if (k == 16) begin
                chk("walk_wrap", 32'(wrap), 32'd1);
                chk("walk_y0", 32'(y), 32'(pol(16'h0001)));
            end else begin
                chk("walk_nowrap", 32'(wrap), 32'd0);
            end
        end

        // dwell 3, changed to 1 mid-line
        start = 1; dwell = 3;
        tick();
        start = 0;
        run(2);
        dwell = 1;
        tick();
        chk("dw_line0", 32'(cur_sel), 32'd0);
        tick();
        chk("dw_line1a", 32'(cur_sel), 32'd1);
        tick();
        chk("dw_line1b", 32'(cur_sel), 32'd1);
        tick();
        chk("dw_line2", 32'(cur_sel), 32'd2);

        // leave scan at line 5 to DIRECT, then disable mid-scan
        start = 1; dwell = 0;
        tick();
        start = 0;
        run(5);
        chk("at_line5", 32'(cur_sel), 32'd5);
        mode = 0; sel = 9;
        tick();
        chk("to_direct", 32'(y), 32'(pol(16'h0200)));
        chk("to_direct_busy", 32'(busy), 32'd0);
        mode = 1; start = 1;
        tick();
        start = 0;
        tick();
        enable = 0;
        tick();
        chk("disable_y", 32'(y), 32'(pol(16'h0)));
        chk("disable_busy", 32'(busy), 32'd0);

        // restart at line 15: no wrap pulse
        enable = 1; start = 1;
        tick();
        start = 0;
        run(15);
        chk("at_line15", 32'(cur_sel), 32'd15);
        start = 1;
        tick();
        chk("restart_y", 32'(y), 32'(pol(16'h0001)));
        chk("restart_wrap", 32'(wrap), 32'd0);
        start = 0;

        // asynchronous reset between edges in mid-scan
        run(4);
        #3 rst = 1;
        #1;
        chk("async_y", 32'(y), 32'(pol(16'h0)));
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        tick();
        rst = 0;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom % 16) != 0;
            mode   = ($urandom % 8) != 0;
            start  = ($urandom % 64) == 0;
            sel    = 4'($urandom);
            dwell  = ($urandom % 16 == 0) ? 8'($urandom % 12)
                                          : 8'($urandom % 3);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
